// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key debounce array.
//   - one-hot FSM state encoding for the per-channel conditioner
//   - polarity helpers (normalise a raw pin, released pin level)
//   - max3 helper used to size the shared counter width
package key_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 4'b0001,
        ST_FILT_DN = 4'b0010,
        ST_DOWN    = 4'b0100,
        ST_FILT_UP = 4'b1000
    } key_st_e;

    // Raw pin -> 1 = pressed.
    function automatic logic norm_level(input logic raw, input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

    // Raw pin level of a key that is not pressed.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one push-button channel.
//   2-FF synchroniser, debounce FSM (IDLE/FILT_DN/DOWN/FILT_UP), hold and
//   auto-repeat timers, registered level and strobes.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   key_in         raw asynchronous pin
//   key_state      debounced level, 1 = pressed
//   press_pulse    1-cycle strobe when a press is accepted
//   release_pulse  1-cycle strobe when a release is accepted
//   long_pulse     1-cycle strobe once the key has been held LONG_CYC
//   repeat_pulse   1-cycle strobe every REP_CYC after long_pulse
module key_debounce_ch
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DEB_CYC    = 1_000_000,
    parameter int LONG_CYC   = 50_000_000,
    parameter int REP_CYC    = 10_000_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = $clog2(max3(DEB_CYC, LONG_CYC, REP_CYC) + 1);

    // The cycle in which IDLE/DOWN first sees the new level is the first of
    // the DEB_CYC stable samples, so the filter state only needs DEB_CYC-1
    // more; that makes pin edge -> strobe exactly 2 + DEB_CYC clocks.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 2);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic             sync1, sync2;
    logic             p;
    key_st_e          state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;

    assign p = norm_level(sync2, ACTIVE_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= released_level(ACTIVE_LOW);
            sync2         <= released_level(ACTIVE_LOW);
            state         <= ST_IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= key_in;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (p) begin
                        state   <= ST_FILT_DN;
                        deb_cnt <= '0;
                    end
                end

                ST_FILT_DN: begin
                    if (!p) begin
                        state <= ST_IDLE;          // glitch, drop silently
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= ST_DOWN;
                        press_pulse <= 1'b1;
                        key_state   <= 1'b1;
                        hold_cnt    <= '0;
                        rep_cnt     <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                ST_DOWN: begin
                    if (!p) begin
                        state   <= ST_FILT_UP;
                        deb_cnt <= '0;
                    end else if (hold_cnt < HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // Parking hold_cnt one past the threshold both
                        // saturates it and marks "long already reported".
                        long_pulse <= 1'b1;
                        hold_cnt   <= hold_cnt + 1'b1;
                    end else if (REPEAT_EN) begin
                        if (rep_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end

                ST_FILT_UP: begin
                    // hold_cnt/rep_cnt are untouched here, so a bounce back
                    // to DOWN resumes the timers where they stopped.
                    if (p) begin
                        state <= ST_DOWN;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        key_state     <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    deb_cnt   <= '0;
                    hold_cnt  <= '0;
                    rep_cnt   <= '0;
                    key_state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// key_debounce_array: N_KEYS independent push-button conditioners.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   key_in         raw key pins
//   key_state      debounced levels, 1 = pressed
//   press_pulse    per-key press strobes
//   release_pulse  per-key release strobes
//   long_pulse     per-key long-press strobes
//   repeat_pulse   per-key auto-repeat strobes
//   any_press      OR of press_pulse (combinational from registered strobes)
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DEB_CYC    = 1_000_000,
    parameter int LONG_CYC   = 50_000_000,
    parameter int REP_CYC    = 10_000_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              any_press
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DEB_CYC    (DEB_CYC),
            .LONG_CYC   (LONG_CYC),
            .REP_CYC    (REP_CYC),
            .REPEAT_EN  (REPEAT_EN)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_in        (key_in[k]),
            .key_state     (key_state[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .long_pulse    (long_pulse[k]),
            .repeat_pulse  (repeat_pulse[k])
        );
    end

    assign any_press = |press_pulse;

endmodule
